// File: rtl/montgomery_pkg.sv
// Shared constants and state encoding for the radix-2 Montgomery multiplier
// controller and anything that drives or observes it.
package montgomery_pkg;

    localparam int unsigned MONT_N  = 512;
    localparam int unsigned MONT_AW = MONT_N + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD_A = 3'd2,
        ADD_M = 3'd3,
        CMP   = 3'd4,
        SUB   = 3'd5,
        DONE  = 3'd6
    } mont_state_t;

endpackage

// File: rtl/mont_cmp.sv
// Unsigned greater-or-equal comparator used for the final conditional subtract.
module mont_cmp #(
    parameter int unsigned W = 515
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_ge
);

    assign o_ge = (i_a >= i_b);

endmodule

// File: rtl/montgomery_ctrl.sv
// Radix-2 Montgomery multiplication sequencer: drives an external accumulating
// adder to compute A*B*2^-N mod M, finishing with one conditional subtract of M.
module montgomery_ctrl
    import montgomery_pkg::*;
#(
    parameter int unsigned N  = MONT_N,
    parameter int unsigned AW = N + 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [N-1:0]  in_m,
    output logic [AW-1:0] add_in,
    output logic          add_en,
    output logic          add_sub,
    output logic          add_shift,
    output logic          add_clear,
    input  logic [AW:0]   add_result,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    mont_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_m;
    logic             r_add_en;
    logic             r_add_sub;
    logic             r_add_shift;
    logic             r_add_clear;
    logic             r_busy;
    logic             r_done;

    logic [AW-1:0]    w_add_in;
    logic [CW-1:0]    w_m_ext;
    logic             w_ge;

    assign w_m_ext = CW'(r_m);

    mont_cmp #(
        .W (CW)
    ) u_cmp (
        .i_a  (add_result),
        .i_b  (w_m_ext),
        .o_ge (w_ge)
    );

    // Control strobes are registered on the transition into the state that uses them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_add_en    <= 1'b0;
            r_add_sub   <= 1'b0;
            r_add_shift <= 1'b0;
            r_add_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_add_en    <= 1'b0;
            r_add_sub   <= 1'b0;
            r_add_shift <= 1'b0;
            r_add_clear <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= in_a;
                        r_b         <= in_b;
                        r_m         <= in_m;
                        r_cnt       <= '0;
                        r_add_clear <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_add_en <= 1'b1;
                    r_state  <= ADD_A;
                end
                ADD_A: begin
                    r_add_en    <= 1'b1;
                    r_add_shift <= 1'b1;
                    r_state     <= ADD_M;
                end
                ADD_M: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= CMP;
                    end else begin
                        r_add_en <= 1'b1;
                        r_state  <= ADD_A;
                    end
                end
                CMP: begin
                    if (w_ge) begin
                        r_add_en  <= 1'b1;
                        r_add_sub <= 1'b1;
                        r_state   <= SUB;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                SUB: begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ADD_M operand depends on the accumulator LSB of the same cycle, so the mux stays combinational.
    always_comb begin
        w_add_in = '0;
        case (r_state)
            ADD_A:   if (r_b[r_cnt])     w_add_in = AW'(r_a);
            ADD_M:   if (add_result[0])  w_add_in = AW'(r_m);
            SUB:                         w_add_in = AW'(r_m);
            default:                     w_add_in = '0;
        endcase
    end

    assign add_in    = w_add_in;
    assign add_en    = r_add_en;
    assign add_sub   = r_add_sub;
    assign add_shift = r_add_shift;
    assign add_clear = r_add_clear;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = add_result[N-1:0];

endmodule

// File: doc/montgomery_ctrl.md
MONTGOMERY_CTRL -- requirements
Module: montgomery_ctrl

Interface
REQ-001 SHALL have parameter N, default 512, giving the operand width in bits.
REQ-002 SHALL have parameter AW, default N+2, giving the adder operand width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin a multiplication; sampled in IDLE only.
REQ-006 SHALL have port in_a, input, N, multiplicand A (A < M).
REQ-007 SHALL have port in_b, input, N, multiplier B (B < M).
REQ-008 SHALL have port in_m, input, N, odd modulus M.
REQ-009 SHALL have port add_in, output, AW, operand driven to the downstream accumulating adder.
REQ-010 SHALL have port add_en, output, 1, adder accumulate enable.
REQ-011 SHALL have port add_sub, output, 1, adder subtract select.
REQ-012 SHALL have port add_shift, output, 1, adder right-shift-by-1 of the sum.
REQ-013 SHALL have port add_clear, output, 1, adder accumulator clear.
REQ-014 SHALL have port add_result, input, AW+1, adder accumulator C.
REQ-015 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-017 SHALL have port result, output, N, equal to add_result[N-1:0]; valid from done until the next start.

Function
REQ-018 SHALL compute C = A*B*2^-N mod M (radix-2 Montgomery) by sequencing the adder.
REQ-019 Adder contract SHALL be: C updates on the edge after add_en=1, giving C <= (C +/- add_in) >> add_shift; add_clear=1 forces C <= 0; the adder has 1-cycle latency.
REQ-020 SHALL latch A, B and M on start acceptance; input changes while busy SHALL have no effect.
REQ-021 SHALL use states IDLE, CLEAR, ADD_A, ADD_M, CMP, SUB, DONE.
REQ-022 IDLE->CLEAR SHALL occur when start=1; CLEAR SHALL last 1 cycle with add_clear=1 and bit counter i=0.
REQ-023 ADD_A SHALL drive add_in = B[i] ? A : 0, add_en=1, add_sub=0, add_shift=0; then go to ADD_M.
REQ-024 ADD_M SHALL set q = add_result[0] (combinational), drive add_in = q ? M : 0, add_en=1, add_shift=1; then i <= i+1.
REQ-025 ADD_M SHALL go to ADD_A when i < N-1, and to CMP when i = N-1.
REQ-026 CMP SHALL compare add_result >= M (width AW+1); if true go to SUB, else go to DONE.
REQ-027 SUB SHALL drive add_in=M, add_en=1, add_sub=1 for 1 cycle, then go to DONE.
REQ-028 DONE SHALL assert done=1 for 1 cycle, then go to IDLE.
REQ-029 Latency SHALL be measured with start sampled at edge 0: CLEAR in cycle 1; ADD_A/ADD_M in cycles 2..2N+1; CMP in cycle 2N+2; done in cycle 2N+3 (no subtraction) or 2N+4 (subtraction).
REQ-030 In every state other than those above, add_en, add_sub, add_shift and add_clear SHALL be 0 and add_in SHALL be 0.
REQ-031 Invariant C < 2M SHALL hold throughout, so no bit beyond AW-1 is ever set.
REQ-032 start=1 while busy SHALL be ignored and no restart queued; start held high across DONE SHALL be accepted in the following IDLE cycle.
REQ-033 A=0 or B=0 SHALL still run the full sequence and yield result 0.

Reset
REQ-034 When resetn=0 at a clock edge, state SHALL become IDLE, i=0, and the latched operands SHALL become 0.
REQ-035 During reset and in IDLE after reset, busy=0, done=0, add_in=0, and add_en=add_sub=add_shift=add_clear=0.
REQ-036 Reset mid-operation SHALL abort with no done pulse; the next start SHALL run a full, correct operation because CLEAR reinitialises the adder.

Structure
REQ-037 A shared package montgomery_pkg SHALL hold N, AW and the state enumeration; the mpadder testbench and this block SHALL both import it.
REQ-038 The single sub-module mont_cmp SHALL be the (AW+1)-bit unsigned >= comparator used in CMP; the bit counter and FSM SHALL be inline.
REQ-039 The adder SHALL NOT be instantiated inside montgomery_ctrl; the two SHALL be connected at the next level up.

Verification (bench SHALL instantiate montgomery_ctrl plus mpadder)
REQ-040 M=3, A=1, B=1 -> result=1; done in cycle 2N+3 or 2N+4.
REQ-041 M=7, A=3, B=5 -> result=2 (2^-512 mod 7 = 2).
REQ-042 M=5, A=3, B=4 -> result=2; A=0, B=4 -> result=0 after the full 2N+3 cycles.
REQ-043 Random 512-bit odd M with A, B < M (Python-generated, 20 vectors) -> result equals the golden model; SUB taken at least once, skipped at least once.
REQ-044 Pulse start in cycle 100 of a run -> no effect, a single done; then resetn=0 at cycle 500 -> busy=0 and no done, followed by a full correct run.
